picosoc_sram_arbiter: RTL and testbench

PICOSOC_SRAM_ARBITER -- requirements
Module: picosoc_sram_arbiter

---
 rtl/picosoc_sram_arbiter.sv | 86 ++++++++
 tb/tb_picosoc_sram_arbiter.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/picosoc_sram_arbiter.sv
// Two-port round-robin arbiter in front of a single-port synchronous SRAM.
// Every transfer takes a fixed three cycles: grant, RAM access, response.
module picosoc_sram_arbiter #(
   parameter int ABITS = 9
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             p0_valid,
   output logic             p0_ready,
   input  logic [31:0]      p0_addr,
   input  logic [31:0]      p0_wdata,
   input  logic [3:0]       p0_wstrb,
   output logic [31:0]      p0_rdata,
   input  logic             p1_valid,
   output logic             p1_ready,
   input  logic [31:0]      p1_addr,
   input  logic [31:0]      p1_wdata,
   input  logic [3:0]       p1_wstrb,
   output logic [31:0]      p1_rdata,
   output logic             ram_cen,
   output logic [3:0]       ram_wen,
   output logic [ABITS-1:0] ram_a,
   output logic [31:0]      ram_d,
   input  logic [31:0]      ram_q
);

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

   state_t state;
   logic   gnt;
   logic   last;
   logic   pick1;

   // On a tie the port that did not win last time gets the RAM.
   assign pick1 = p1_valid & (~p0_valid | ~last);

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         gnt      <= 1'b0;
         last     <= 1'b1;
         ram_cen  <= 1'b1;
         ram_wen  <= 4'hF;
         ram_a    <= '0;
         ram_d    <= '0;
         p0_ready <= 1'b0;
         p1_ready <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (p0_valid | p1_valid) begin
                  gnt     <= pick1;
                  last    <= pick1;
                  ram_cen <= 1'b0;
                  ram_a   <= pick1 ? p1_addr[ABITS+1:2] : p0_addr[ABITS+1:2];
                  ram_d   <= pick1 ? p1_wdata : p0_wdata;
                  ram_wen <= pick1 ? ~p1_wstrb : ~p0_wstrb;
                  state   <= ACCESS;
               end
            end
            ACCESS: begin
               ram_cen  <= 1'b1;
               ram_wen  <= 4'hF;
               p0_ready <= ~gnt;
               p1_ready <= gnt;
               state    <= RESP;
            end
            RESP: begin
               p0_ready <= 1'b0;
               p1_ready <= 1'b0;
               state    <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // ram_q is only meaningful in the response cycle; gate it to the winner.
   assign p0_rdata = p0_ready ? ram_q : 32'h0;
   assign p1_rdata = p1_ready ? ram_q : 32'h0;

   logic unused_addr;
   assign unused_addr = ^{p0_addr[31:ABITS+2], p0_addr[1:0],
                          p1_addr[31:ABITS+2], p1_addr[1:0]};

endmodule

// File: tb/tb_picosoc_sram_arbiter.sv
// Bench for picosoc_sram_arbiter: behavioural SRAM, directed stimulus and a
// scoreboard monitor that checks every ready pulse against queued expectations.
module tb_picosoc_sram_arbiter;
   localparam int ABITS = 9;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             p0_valid = 0, p1_valid = 0;
   logic             p0_ready, p1_ready;
   logic [31:0]      p0_addr = 0, p1_addr = 0, p0_wdata = 0, p1_wdata = 0;
   logic [3:0]       p0_wstrb = 0, p1_wstrb = 0;
   logic [31:0]      p0_rdata, p1_rdata;
   logic             ram_cen;
   logic [3:0]       ram_wen;
   logic [ABITS-1:0] ram_a;
   logic [31:0]      ram_d;
   logic [31:0]      ram_q = 0;

   picosoc_sram_arbiter #(.ABITS(ABITS)) dut (
      .clk(clk), .rst(rst),
      .p0_valid(p0_valid), .p0_ready(p0_ready), .p0_addr(p0_addr),
      .p0_wdata(p0_wdata), .p0_wstrb(p0_wstrb), .p0_rdata(p0_rdata),
      .p1_valid(p1_valid), .p1_ready(p1_ready), .p1_addr(p1_addr),
      .p1_wdata(p1_wdata), .p1_wstrb(p1_wstrb), .p1_rdata(p1_rdata),
      .ram_cen(ram_cen), .ram_wen(ram_wen), .ram_a(ram_a),
      .ram_d(ram_d), .ram_q(ram_q)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Read-before-write synchronous SRAM with active-low byte enables.
   logic [31:0] mem [0:(1<<ABITS)-1];
   initial for (int i = 0; i < (1 << ABITS); i++) mem[i] = 32'h0;
   always @(posedge clk) begin
      if (!ram_cen) begin
         for (int b = 0; b < 4; b++)
            if (!ram_wen[b]) mem[ram_a][b*8 +: 8] <= ram_d[b*8 +: 8];
         ram_q <= mem[ram_a];
      end
   end

   typedef struct {
      bit               port;
      bit               chk_rd;
      logic [31:0]      rdata;
      logic [ABITS-1:0] a;
      logic [3:0]       wen;
      logic [31:0]      d;
      int               cyc;
   } exp_t;

   exp_t exp_q [$];
   int checks = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: actual=%h required=%h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Monitor: captures the RAM strobe cycle and scores every ready pulse.
   int               cen_cnt = 0;
   logic [ABITS-1:0] cap_a;
   logic [3:0]       cap_wen;
   logic [31:0]      cap_d;
   always @(negedge clk) begin
      if (rst) cen_cnt = 0;
      else begin
         if (!ram_cen) begin
            cen_cnt++;
            cap_a = ram_a; cap_wen = ram_wen; cap_d = ram_d;
         end
         chk("both_ready", {31'h0, p0_ready & p1_ready}, 32'h0);
         if (!p0_ready) chk("p0_rdata_idle", p0_rdata, 32'h0);
         if (!p1_ready) chk("p1_rdata_idle", p1_rdata, 32'h0);
         if (p0_ready | p1_ready) begin
            if (exp_q.size() == 0) chk("unexpected_ready", 32'h1, 32'h0);
            else begin
               exp_t e;
               e = exp_q.pop_front();
               chk("ready_port", {31'h0, p1_ready}, {31'h0, e.port});
               chk("ready_cycle", cyc, e.cyc);
               chk("ram_a", 32'(cap_a), 32'(e.a));
               chk("ram_wen", {28'h0, cap_wen}, {28'h0, e.wen});
               chk("cen_low_cycles", cen_cnt, 1);
               if (e.wen != 4'hF) chk("ram_d", cap_d, e.d);
               if (e.chk_rd) chk("rdata", e.port ? p1_rdata : p0_rdata, e.rdata);
            end
            cen_cnt = 0;
         end
      end
   end

   task automatic drive(input bit port, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] wstrb);
      if (port) begin p1_valid = 1; p1_addr = addr; p1_wdata = wdata; p1_wstrb = wstrb; end
      else      begin p0_valid = 1; p0_addr = addr; p0_wdata = wdata; p0_wstrb = wstrb; end
   endtask

   task automatic expect_xfer(input bit port, input bit chk_rd, input logic [31:0] rdata,
                              input logic [ABITS-1:0] a, input logic [3:0] wen,
                              input logic [31:0] d, input int at);
      exp_t e;
      e.port = port; e.chk_rd = chk_rd; e.rdata = rdata; e.a = a;
      e.wen = wen; e.d = d; e.cyc = at;
      exp_q.push_back(e);
   endtask

   // One isolated transfer issued in IDLE; ready expected two cycles later.
   task automatic xfer(input bit port, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] wstrb, input bit chk_rd, input logic [31:0] rdata,
                       input logic [ABITS-1:0] a, input logic [3:0] wen);
      @(posedge clk); #1;
      drive(port, addr, wdata, wstrb);
      expect_xfer(port, chk_rd, rdata, a, wen, wdata, cyc + 2);
      repeat (3) @(posedge clk);
      #1 p0_valid = 0; p1_valid = 0;
   endtask

   task automatic pulse_reset();
      @(posedge clk); #1 rst = 1;
      repeat (2) @(posedge clk);
      #1 rst = 0;
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1 rst = 0;
      chk("rst_cen", {31'h0, ram_cen}, 32'h1);
      chk("rst_wen", {28'h0, ram_wen}, 32'hF);
      chk("rst_a", 32'(ram_a), 32'h0);
      chk("rst_d", ram_d, 32'h0);
      chk("rst_ready", {30'h0, p1_ready, p0_ready}, 32'h0);

      // Full write then read-back through p0.
      xfer(0, 32'h10, 32'hDEADBEEF, 4'hF, 0, 32'h0, 9'd4, 4'h0);
      xfer(0, 32'h10, 32'h0, 4'h0, 1, 32'hDEADBEEF, 9'd4, 4'hF);
      // Partial write through p1: only bytes 0 and 2 change.
      xfer(1, 32'h10, 32'h00AA0055, 4'b0101, 0, 32'h0, 9'd4, 4'b1010);
      xfer(1, 32'h10, 32'h0, 4'h0, 1, 32'hDEAABE55, 9'd4, 4'hF);
      // Address wrap: 0x804 aliases word 1; low two bits ignored.
      xfer(1, 32'h7, 32'h12345678, 4'hF, 0, 32'h0, 9'd1, 4'h0);
      xfer(0, 32'h0000_0804, 32'h0, 4'h0, 1, 32'h12345678, 9'd1, 4'hF);

      // Round robin with both valids held after reset.
      pulse_reset();
      @(posedge clk); #1;
      drive(0, 32'h10, 32'h0, 4'h0);
      drive(1, 32'h4, 32'h0, 4'h0);
      expect_xfer(0, 1, 32'hDEAABE55, 9'd4, 4'hF, 32'h0, cyc + 2);
      expect_xfer(1, 1, 32'h12345678, 9'd1, 4'hF, 32'h0, cyc + 5);
      expect_xfer(0, 1, 32'hDEAABE55, 9'd4, 4'hF, 32'h0, cyc + 8);
      expect_xfer(1, 1, 32'h12345678, 9'd1, 4'hF, 32'h0, cyc + 11);
      repeat (12) @(posedge clk);
      #1 p0_valid = 0; p1_valid = 0;

      // Reset during ACCESS aborts; the held valid is re-granted.
      @(posedge clk); #1;
      drive(0, 32'h10, 32'h0, 4'h0);
      @(posedge clk); #1 rst = 1;
      @(posedge clk); #1 rst = 0;
      chk("abort_cen", {31'h0, ram_cen}, 32'h1);
      chk("abort_ready", {30'h0, p1_ready, p0_ready}, 32'h0);
      expect_xfer(0, 1, 32'hDEAABE55, 9'd4, 4'hF, 32'h0, cyc + 2);
      repeat (3) @(posedge clk);
      #1 p0_valid = 0;

      // p1 drops valid and scrambles its inputs in ACCESS; p0 then follows.
      @(posedge clk); #1;
      drive(1, 32'h4, 32'h0, 4'h0);
      expect_xfer(1, 1, 32'h12345678, 9'd1, 4'hF, 32'h0, cyc + 2);
      expect_xfer(0, 1, 32'hDEAABE55, 9'd4, 4'hF, 32'h0, cyc + 5);
      @(posedge clk); #1;
      p1_valid = 0; p1_addr = 32'h1F0; p1_wstrb = 4'hF; p1_wdata = 32'hBAD0BAD0;
      drive(0, 32'h10, 32'h0, 4'h0);
      repeat (5) @(posedge clk);
      #1 p0_valid = 0;

      repeat (6) @(posedge clk);
      #1 chk("pending_expectations", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
